zxw_lab_2: RTL and testbench

- Minimal 8-bit accumulator microprocessor for the lab board: 5 switches in, one 8-bit display register out.
- A fixed 32-entry instruction ROM holds a program that reads the switches and counts down to zero on the display, then shows 0x20 and halts.
- One instruction executes per clock; top-level lab block with no external memory.

---
 rtl/zxw_lab_2_if.sv | 9 +
 rtl/zxw_lab_2.sv | 90 +++++++++
 tb/tb_zxw_lab_2.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/zxw_lab_2_if.sv
// Lab-board I/O bundle: switch input toward the core, display register back out.
// The core takes the slave side; the board (or bench) takes the master side.
interface zxw_lab_2_if;
   logic [4:0] SW_in;
   logic [7:0] Display_out;

   modport master (output SW_in, input Display_out);
   modport slave  (input SW_in, output Display_out);
endinterface

// File: rtl/zxw_lab_2.sv
// 8-bit accumulator core that runs a fixed 32-entry ROM program, one instruction
// per clock: it counts the switch value down to zero on the display, shows 0x20, then halts.
module zxw_lab_2 (
   input  logic        Clock,
   input  logic        Resetn,   // active-high synchronous reset despite the name
   zxw_lab_2_if.slave  io
);

   typedef enum logic [2:0] {
      OP_LDI  = 3'b000,
      OP_ADDI = 3'b001,
      OP_SUBI = 3'b010,
      OP_IN   = 3'b011,
      OP_OUT  = 3'b100,
      OP_JZ   = 3'b101,
      OP_JMP  = 3'b110,
      OP_HALT = 3'b111
   } opcode_e;

   logic [4:0] pc_q, pc_d;
   logic [7:0] a_q, a_d;
   logic [7:0] disp_q, disp_d;
   logic       halted_q, halted_d;

   logic [7:0] instr;
   opcode_e    op;
   logic [4:0] imm5;

   always_comb begin
      instr = 8'hE0;
      case (pc_q)
         5'd0:    instr = 8'h60;
         5'd1:    instr = 8'h80;
         5'd2:    instr = 8'hA6;
         5'd3:    instr = 8'h41;
         5'd4:    instr = 8'h80;
         5'd5:    instr = 8'hC2;
         5'd6:    instr = 8'h1F;
         5'd7:    instr = 8'h21;
         5'd8:    instr = 8'h80;
         default: instr = 8'hE0;
      endcase
   end

   assign op   = opcode_e'(instr[7:5]);
   assign imm5 = instr[4:0];

   always_comb begin
      pc_d     = pc_q + 5'd1;
      a_d      = a_q;
      disp_d   = disp_q;
      halted_d = halted_q;
      // Once halted, everything freezes until reset.
      if (halted_q) begin
         pc_d = pc_q;
      end else begin
         case (op)
            OP_LDI:  a_d = {3'b000, imm5};
            OP_ADDI: a_d = a_q + {3'b000, imm5};
            OP_SUBI: a_d = a_q - {3'b000, imm5};
            OP_IN:   a_d = {3'b000, io.SW_in};
            OP_OUT:  disp_d = a_q;
            OP_JZ:   if (a_q == 8'h00) pc_d = imm5;
            OP_JMP:  pc_d = imm5;
            OP_HALT: begin
               halted_d = 1'b1;
               pc_d     = pc_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Resetn) begin
         pc_q     <= 5'd0;
         a_q      <= 8'h00;
         disp_q   <= 8'h00;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         a_q      <= a_d;
         disp_q   <= disp_d;
         halted_q <= halted_d;
      end
   end

   assign io.Display_out = disp_q;

endmodule

// File: tb/tb_zxw_lab_2.sv
// Directed bench for the counting-display ROM program: reset behaviour, several
// switch values, switch changes after the IN edge and mid-program reset.
module tb_zxw_lab_2;

   logic Clock;
   logic Resetn;
   int   total;
   int   bad;

   zxw_lab_2_if bus ();

   zxw_lab_2 dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .io     (bus.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Advance one rising edge and settle away from it.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reset for a few edges, leaving the bench just after the last reset edge.
   task automatic do_reset();
      Resetn = 1'b1;
      tick(3);
      Resetn = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      Resetn = 1'b1;
      bus.SW_in = 5'd0;

      // SW_in = 0
      tick(2);
      chk("rst_disp", bus.Display_out, 8'h00);
      chk("rst_pc", {3'b0, dut.pc_q}, 8'h00);
      Resetn = 1'b0;
      chk("rel_disp", bus.Display_out, 8'h00);
      tick(2);
      chk("n0_e2", bus.Display_out, 8'h00);
      tick(4);
      chk("n0_e6", bus.Display_out, 8'h20);
      chk("n0_e6_run", {7'b0, dut.halted_q}, 8'h00);
      tick(1);
      chk("n0_e7_halt", {7'b0, dut.halted_q}, 8'h01);
      for (int i = 0; i < 85; i++) begin
         tick(1);
         chk("n0_hold", bus.Display_out, 8'h20);
      end
      chk("n0_pc_frozen", {3'b0, dut.pc_q}, 8'h09);
      // Reset clears a non-zero display
      Resetn = 1'b1;
      tick(1);
      chk("rst_clr_disp", bus.Display_out, 8'h00);
      chk("rst_clr_halt", {7'b0, dut.halted_q}, 8'h00);

      // SW_in = 3
      bus.SW_in = 5'd3;
      do_reset();
      tick(2);  chk("n3_e2",  bus.Display_out, 8'h03);
      tick(4);  chk("n3_e6",  bus.Display_out, 8'h02);
      tick(4);  chk("n3_e10", bus.Display_out, 8'h01);
      tick(4);  chk("n3_e14", bus.Display_out, 8'h00);
      tick(4);  chk("n3_e18", bus.Display_out, 8'h20);
      chk("n3_e18_run", {7'b0, dut.halted_q}, 8'h00);
      tick(1);  chk("n3_e19_halt", {7'b0, dut.halted_q}, 8'h01);

      // SW_in changed 3 -> 7 after the IN edge has no effect
      bus.SW_in = 5'd3;
      do_reset();
      tick(1);
      bus.SW_in = 5'd7;
      tick(1);  chk("sw_e2",  bus.Display_out, 8'h03);
      tick(4);  chk("sw_e6",  bus.Display_out, 8'h02);
      tick(4);  chk("sw_e10", bus.Display_out, 8'h01);
      tick(4);  chk("sw_e14", bus.Display_out, 8'h00);
      tick(4);  chk("sw_e18", bus.Display_out, 8'h20);
      tick(1);  chk("sw_e19_halt", {7'b0, dut.halted_q}, 8'h01);

      // SW_in = 31
      bus.SW_in = 5'd31;
      do_reset();
      tick(2);
      for (int j = 0; j < 32; j++) begin
         chk("n31_count", bus.Display_out, 8'(31 - j));
         tick(4);
      end
      // now just after edge 130
      chk("n31_e130", bus.Display_out, 8'h20);
      chk("n31_e130_run", {7'b0, dut.halted_q}, 8'h00);
      tick(1);
      chk("n31_e131_halt", {7'b0, dut.halted_q}, 8'h01);

      // Reset mid-count
      bus.SW_in = 5'd5;
      do_reset();
      tick(10);
      chk("mid_e10", bus.Display_out, 8'h03);
      Resetn = 1'b1;
      tick(1);
      chk("mid_rst_disp", bus.Display_out, 8'h00);
      chk("mid_rst_pc", {3'b0, dut.pc_q}, 8'h00);
      Resetn = 1'b0;
      tick(2);
      chk("mid_rerun_e2", bus.Display_out, 8'h05);

      // Long reset: nothing executes
      Resetn = 1'b1;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         chk("long_rst_disp", bus.Display_out, 8'h00);
         chk("long_rst_pc", {3'b0, dut.pc_q}, 8'h00);
      end
      Resetn = 1'b0;
      tick(2);
      chk("post_long_e2", bus.Display_out, 8'h05);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
